instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the MIPS processor, directly upstream of `instruction_mem`. Holds the program counter, drives `cpu_pc` into the instruction memory and captures the returned 16-bit `cpu_instruction` into the IF/ID pipeline register. Handles sequential advance, stall, flush, branch/jump redirect and end-of-program detection.

## Interface
- `PC_WIDTH`, 16: program counter width; byte address.
- `DATA_SIZE`, 16: instruction width.
- `INSTR_NUM`, 15: number of instructions in ROM. `LAST_PC = 2*(INSTR_NUM-1)`.
- `RESET_PC`, 0: PC value after reset. Even, and ≤ `LAST_PC`.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and IF/ID.
- `flush`  in  1  load a bubble into IF/ID.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  PC_WIDTH  branch destination.
- `jump`  in  1  redirect to `jump_target`.
- `jump_target`  in  PC_WIDTH  jump destination.
- `cpu_pc`  out  PC_WIDTH  current PC to `instruction_mem`.
- `cpu_instruction`  in  DATA_SIZE  combinational read data from `instruction_mem`.
- `ifid_instr`  out  DATA_SIZE  fetched instruction.
- `ifid_pc_plus2`  out  PC_WIDTH  PC of the fetched instruction + 2.
- `ifid_valid`  out  1  IF/ID holds a real instruction.
- `fetch_done`  out  1  program end reached; fetch idle.

## Operation
- All state is updated on the rising edge of `clk`. The evaluation priority is `reset` > redirect > `flush` > `stall` > `fetch_done` hold > advance.
- **Reset.**
  - `cpu_pc` = `RESET_PC`.
  - `ifid_instr` = `NOP_INSTR` (0).
  - `ifid_pc_plus2` = 0.
  - `ifid_valid` = 0.
  - `fetch_done` = 0.
- **Redirect** (`jump` or `branch_taken`):
  - `jump` wins if both are asserted.
  - Target bit 0 is forced to 0.
  - PC loads the target.
  - IF/ID loads a bubble: instr = NOP, valid = 0, pc_plus2 unchanged.
  - `fetch_done` <= (target > `LAST_PC`).
  - Redirect overrides `stall` and `flush`.
- **Flush** (no redirect): IF/ID loads a bubble. PC advances unless `stall` is high; with `stall` high the PC holds.
- **Stall** (no redirect, no flush): PC, IF/ID and `fetch_done` all hold.
- **Done hold:** while `fetch_done`=1 with no redirect:
  - PC holds.
  - IF/ID loads a bubble each cycle.
- **Advance:**
  - IF/ID <= {`cpu_instruction`, `cpu_pc`+2, valid=1}.
  - If `cpu_pc` < `LAST_PC`: PC <= PC+2.
  - If `cpu_pc` == `LAST_PC`: PC holds, `fetch_done` <= 1. The last instruction is still captured valid.
- **Arithmetic:** PC+2 is computed modulo 2^PC_WIDTH. Wrap cannot occur in normal advance because of `LAST_PC`. `ifid_pc_plus2` wraps naturally.

## Timing
- `cpu_pc` is a register output. `cpu_instruction` is sampled the same cycle; ROM read is combinational.
- Fetch latency: one cycle from `cpu_pc` = A to `ifid_instr` = mem[A/2], `ifid_valid`=1.
- The first valid IF/ID comes at the first edge after `reset` deasserts.
- Redirect asserted in cycle N:
  - `cpu_pc` = target in cycle N+1.
  - Target instruction is valid in IF/ID in cycle N+2.
  - One bubble in between.
- Reset asserted mid-operation takes effect at the next edge regardless of other inputs. In-flight IF/ID contents are discarded.

## Structure
- Shared package `mips_pkg`:
  - `NOP_INSTR` (16'h0000).
  - `PC_STEP` (2).
  - Enum `redirect_e` {`REDIR_NONE`, `REDIR_BRANCH`, `REDIR_JUMP`}.
- One natural sub-module: `ifid_reg`. It holds the IF/ID register with load, hold and bubble controls.
- Next-PC select and the `fetch_done` flag stay in `instruction_fetch`.

## Test plan
- **Reset then free-run** with INSTR_NUM=15:
  - `cpu_pc` steps 0,2,4,…,28.
  - IF/ID shows mem[0..14], all valid.
  - At `cpu_pc`=28, `fetch_done`=1 one cycle later, PC stays 28, subsequent IF/ID are bubbles.
- **Stall at `cpu_pc`=6 for 3 cycles:**
  - `cpu_pc` stays 6.
  - IF/ID holds mem[2] with pc_plus2=6.
  - After release, the next IF/ID is mem[3].
- **`branch_taken` with target 0x0015 at `cpu_pc`=8:**
  - Next `cpu_pc`=0x0014, IF/ID bubble.
  - Following cycle IF/ID = mem[10], pc_plus2=0x16.
- **`jump`=1 (target 0x0002) and `branch_taken`=1 (target 0x000A) with `stall`=1:**
  - Jump wins, `cpu_pc`=2.
  - A done state is cleared by this redirect.
- **Redirect to 0x0040 (> `LAST_PC`):** `fetch_done`=1, PC=0x40, IF/ID bubbles until a redirect to 0x0000 restarts fetch.
- **`flush` with `stall`:** IF/ID becomes a bubble, PC holds. **`reset`** mid-run with `stall`=1 returns all outputs to their reset values.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: bubble encoding, PC step size,
// redirect source and fetch state encodings.
package mips_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int unsigned PC_STEP   = 2;

  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BRANCH,
    REDIR_JUMP
  } redirect_e;

  typedef enum logic {
    ST_FETCH,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory bus between the fetch stage (master) and the ROM (slave).
interface instruction_fetch_if #(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned DATA_SIZE = 16
);

  logic [PC_WIDTH-1:0]  cpu_pc;
  logic [DATA_SIZE-1:0] cpu_instruction;

  modport master (output cpu_pc, input  cpu_instruction);
  modport slave  (input  cpu_pc, output cpu_instruction);

endinterface

// File: rtl/instruction_fetch_ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// A bubble clears the instruction and valid bit but keeps pc_plus2.
module ifid_reg
  import mips_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 bubble,
  input  logic [DATA_SIZE-1:0] instr_in,
  input  logic [PC_WIDTH-1:0]  pc_plus2_in,
  output logic [DATA_SIZE-1:0] instr,
  output logic [PC_WIDTH-1:0]  pc_plus2,
  output logic                 valid
);

  // Pipeline register update: reset > bubble > load > hold
  always_ff @(posedge clk) begin
    if (reset) begin
      instr    <= DATA_SIZE'(NOP_INSTR);
      pc_plus2 <= '0;
      valid    <= 1'b0;
    end else if (bubble) begin
      instr    <= DATA_SIZE'(NOP_INSTR);
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= instr_in;
      pc_plus2 <= pc_plus2_in;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, next-PC select, end-of-program detection,
// and the IF/ID register fed from the instruction memory bus.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 16,
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned INSTR_NUM = 15,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  input  logic                 jump,
  input  logic [PC_WIDTH-1:0]  jump_target,
  instruction_fetch_if.master  mem,
  output logic [DATA_SIZE-1:0] ifid_instr,
  output logic [PC_WIDTH-1:0]  ifid_pc_plus2,
  output logic                 ifid_valid,
  output logic                 fetch_done
);

  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(2 * (INSTR_NUM - 1));
  localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);

  logic [PC_WIDTH-1:0] pc, pc_next, pc_plus2, target;
  fetch_state_e        state, state_next;
  redirect_e           redir;
  logic                ifid_load, ifid_bubble;

  assign mem.cpu_pc = pc;
  assign pc_plus2   = pc + PC_WIDTH'(PC_STEP);
  assign fetch_done = (state == ST_DONE);

  // Redirect source select; jump outranks branch, target forced halfword aligned
  always_comb begin
    redir = REDIR_NONE;
    if (jump)              redir = REDIR_JUMP;
    else if (branch_taken) redir = REDIR_BRANCH;
    target    = (redir == REDIR_JUMP) ? jump_target : branch_target;
    target[0] = 1'b0;
  end

  // PC and fetch state register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_INIT;
      state <= ST_FETCH;
    end else begin
      pc    <= pc_next;
      state <= state_next;
    end
  end

  // Next PC, next fetch state and IF/ID control in priority order
  always_comb begin
    pc_next     = pc;
    state_next  = state;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    if (redir != REDIR_NONE) begin
      pc_next     = target;
      ifid_bubble = 1'b1;
      state_next  = (target > LAST_PC) ? ST_DONE : ST_FETCH;
    end else if (flush) begin
      ifid_bubble = 1'b1;
      // A flushed slot still consumes its fetch, so the end-of-program
      // check applies exactly as for a normal advance.
      if (!stall && state == ST_FETCH) begin
        if (pc < LAST_PC) pc_next    = pc_plus2;
        else              state_next = ST_DONE;
      end
    end else if (stall) begin
      // everything holds
    end else if (state == ST_DONE) begin
      ifid_bubble = 1'b1;
    end else begin
      ifid_load = 1'b1;
      if (pc < LAST_PC) pc_next    = pc_plus2;
      else              state_next = ST_DONE;
    end
  end

  ifid_reg #(
    .PC_WIDTH  (PC_WIDTH),
    .DATA_SIZE (DATA_SIZE)
  ) u_ifid_reg (
    .clk         (clk),
    .reset       (reset),
    .load        (ifid_load),
    .bubble      (ifid_bubble),
    .instr_in    (mem.cpu_instruction),
    .pc_plus2_in (pc_plus2),
    .instr       (ifid_instr),
    .pc_plus2    (ifid_pc_plus2),
    .valid       (ifid_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 15-entry combinational ROM model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken, jump;
  logic [15:0] branch_target, jump_target;
  logic [15:0] ifid_instr, ifid_pc_plus2, rom_data;
  logic        ifid_valid, fetch_done;
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  instruction_fetch_if #(.PC_WIDTH(16), .DATA_SIZE(16)) bus ();

  instruction_fetch #(
    .PC_WIDTH  (16),
    .DATA_SIZE (16),
    .INSTR_NUM (15),
    .RESET_PC  (0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .mem           (bus),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .fetch_done    (fetch_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] memv(int i);
    return 16'h1000 + 16'(i) * 16'h0111;
  endfunction

  always_comb begin
    if (bus.cpu_pc[15:1] < 15'd15) rom_data = memv(int'(bus.cpu_pc[15:1]));
    else                           rom_data = 16'hDEAD;
  end
  assign bus.cpu_instruction = rom_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string step, logic [15:0] pc, logic [15:0] instr,
                           logic [15:0] pp2, logic valid, logic done);
    chk({step, ".cpu_pc"},        32'(bus.cpu_pc),     32'(pc));
    chk({step, ".ifid_instr"},    32'(ifid_instr),     32'(instr));
    chk({step, ".ifid_pc_plus2"}, 32'(ifid_pc_plus2),  32'(pp2));
    chk({step, ".ifid_valid"},    32'(ifid_valid),     32'(valid));
    chk({step, ".fetch_done"},    32'(fetch_done),     32'(done));
  endtask

  task automatic idle();
    stall = 0; flush = 0; branch_taken = 0; jump = 0;
    branch_target = '0; jump_target = '0;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    check_all("reset", 16'h0, 16'h0, 16'h0, 0, 0);
    reset = 0;

    // free run to end of program
    for (int k = 0; k < 15; k++) begin
      tick();
      check_all($sformatf("run%0d", k), (k < 14) ? 16'(2*k+2) : 16'd28,
                memv(k), 16'(2*k+2), 1, (k == 14));
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      check_all("done_hold", 16'd28, 16'h0, 16'd30, 0, 1);
    end

    // jump and branch together under stall: jump wins, done cleared
    jump = 1; jump_target = 16'h0002;
    branch_taken = 1; branch_target = 16'h000A; stall = 1;
    tick();
    check_all("jump_vs_branch", 16'h2, 16'h0, 16'd30, 0, 0);
    idle();
    tick();
    check_all("after_jump1", 16'h4, memv(1), 16'h4, 1, 0);
    tick();
    check_all("after_jump2", 16'h6, memv(2), 16'h6, 1, 0);

    // stall at pc 6 for three cycles
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_all("stall", 16'h6, memv(2), 16'h6, 1, 0);
    end
    stall = 0;
    tick();
    check_all("stall_release", 16'h8, memv(3), 16'h8, 1, 0);

    // branch to odd target at pc 8
    branch_taken = 1; branch_target = 16'h0015;
    tick();
    check_all("branch", 16'h14, 16'h0, 16'h8, 0, 0);
    idle();
    tick();
    check_all("branch_tgt", 16'h16, memv(10), 16'h16, 1, 0);

    // flush with stall holds PC, flush alone advances
    flush = 1; stall = 1;
    tick();
    check_all("flush_stall", 16'h16, 16'h0, 16'h16, 0, 0);
    stall = 0;
    tick();
    check_all("flush", 16'h18, 16'h0, 16'h16, 0, 0);
    flush = 0;
    tick();
    check_all("flush_after", 16'h1A, memv(12), 16'h1A, 1, 0);

    // redirect beyond end of program
    jump = 1; jump_target = 16'h0040;
    tick();
    check_all("jump_far", 16'h40, 16'h0, 16'h1A, 0, 1);
    idle();
    for (int k = 0; k < 2; k++) begin
      tick();
      check_all("far_hold", 16'h40, 16'h0, 16'h1A, 0, 1);
    end
    jump = 1; jump_target = 16'h0000;
    tick();
    check_all("restart", 16'h0, 16'h0, 16'h1A, 0, 0);
    idle();
    tick();
    check_all("restart1", 16'h2, memv(0), 16'h2, 1, 0);
    tick();
    check_all("restart2", 16'h4, memv(1), 16'h4, 1, 0);

    // reset mid-run with stall asserted
    reset = 1; stall = 1;
    tick();
    check_all("reset_mid", 16'h0, 16'h0, 16'h0, 0, 0);
    reset = 0; stall = 0;
    tick();
    check_all("post_reset", 16'h2, memv(0), 16'h2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
